// File: rtl/regfile_pkg.sv
// Shared register-file constants and address helpers.
// The scoreboard and its hazard checker both use them.
package regfile_pkg;

    localparam int REG_ADDR_W = 7;
    localparam int NUM_REGS   = 128;
    localparam int DATA_W     = 128;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG  = 7'd0;
    localparam logic [REG_ADDR_W-1:0] CONST_REG = 7'd20;

    // The hard-wired zero and constant registers are never tracked.
    function automatic logic is_reservable(input logic [REG_ADDR_W-1:0] addr);
        return (addr != ZERO_REG) && (addr != CONST_REG);
    endfunction

    // True when any used source field {c,b,a} names addr.
    function automatic logic src_match(input logic [3*REG_ADDR_W-1:0] src,
                                       input logic [2:0]              use_mask,
                                       input logic [REG_ADDR_W-1:0]   addr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (use_mask[i] && (src[i*REG_ADDR_W +: REG_ADDR_W] == addr))
                hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/scb_hazard_check.sv
// Solo issue check for one core: RAW on the used sources, WAW on the
// destination, and the reservation capacity limit.
module scb_hazard_check
    import regfile_pkg::*;
#(
    parameter int MAX_BUSY = 32
) (
    input  logic [NUM_REGS-1:0]     busy_vec,
    input  logic [7:0]              busy_count,
    input  logic [3*REG_ADDR_W-1:0] src,
    input  logic [2:0]              src_use,
    input  logic [REG_ADDR_W-1:0]   dst,
    input  logic                    dst_use,
    output logic                    ok,
    output logic                    reserves
);

    localparam logic [7:0] MAX_B = 8'(MAX_BUSY);

    logic [2:0] src_hit;

    // Non-reservable registers never carry a busy bit, so they never hit.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi]
                               && busy_vec[src[gi*REG_ADDR_W +: REG_ADDR_W]];
        end
    endgenerate

    assign reserves = dst_use && is_reservable(dst);

    assign ok = !(|src_hit)
             && !(dst_use && busy_vec[dst])
             && (!reserves || (busy_count < MAX_B));

endmodule

// File: rtl/reg_scoreboard.sv
// Dual-core issue scoreboard for the shared register file: one busy bit per
// register, set on a granted reserving issue and cleared on writeback.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int MAX_BUSY = 32,
    parameter int STALL_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    iss_valid_1,
    output logic                    iss_ready_1,
    input  logic [3*REG_ADDR_W-1:0] iss_src_1,
    input  logic [2:0]              iss_src_use_1,
    input  logic [REG_ADDR_W-1:0]   iss_dst_1,
    input  logic                    iss_dst_use_1,
    input  logic                    iss_valid_2,
    output logic                    iss_ready_2,
    input  logic [3*REG_ADDR_W-1:0] iss_src_2,
    input  logic [2:0]              iss_src_use_2,
    input  logic [REG_ADDR_W-1:0]   iss_dst_2,
    input  logic                    iss_dst_use_2,
    input  logic                    wb_valid_1,
    input  logic [REG_ADDR_W-1:0]   wb_addr_1,
    input  logic                    wb_valid_2,
    input  logic [REG_ADDR_W-1:0]   wb_addr_2,
    output logic [NUM_REGS-1:0]     busy_vec,
    output logic [7:0]              busy_count,
    output logic [STALL_W-1:0]      stall_cnt_1,
    output logic [STALL_W-1:0]      stall_cnt_2,
    output logic                    wb_err
);

    localparam logic [7:0] MAX_B = 8'(MAX_BUSY);

    logic [NUM_REGS-1:0] busy_reg, busy_next, set_vec, clr_vec;
    logic [7:0]          count_reg, count_next;
    logic                prio_reg, prio_next;
    logic [STALL_W-1:0]  stall_1_reg, stall_2_reg;
    logic                err_reg, err_next;

    logic ok_1, ok_2, res_1, res_2;
    logic hits_1, hits_2, cap_clash, conflict;
    logic grant_1, grant_2, clr_1, clr_2;
    logic [1:0] set_n, clr_n;

    scb_hazard_check #(.MAX_BUSY(MAX_BUSY)) u_check_1 (
        .busy_vec(busy_reg), .busy_count(count_reg),
        .src(iss_src_1), .src_use(iss_src_use_1),
        .dst(iss_dst_1), .dst_use(iss_dst_use_1),
        .ok(ok_1), .reserves(res_1)
    );

    scb_hazard_check #(.MAX_BUSY(MAX_BUSY)) u_check_2 (
        .busy_vec(busy_reg), .busy_count(count_reg),
        .src(iss_src_2), .src_use(iss_src_use_2),
        .dst(iss_dst_2), .dst_use(iss_dst_use_2),
        .ok(ok_2), .reserves(res_2)
    );

    // Two individually legal issues can still collide with each other.
    assign hits_1 = res_1 && ((iss_dst_use_2 && (iss_dst_2 == iss_dst_1))
                              || src_match(iss_src_2, iss_src_use_2, iss_dst_1));
    assign hits_2 = res_2 && ((iss_dst_use_1 && (iss_dst_1 == iss_dst_2))
                              || src_match(iss_src_1, iss_src_use_1, iss_dst_2));
    assign cap_clash = res_1 && res_2 && (count_reg == MAX_B - 8'd1);
    assign conflict  = iss_valid_1 && iss_valid_2 && ok_1 && ok_2
                    && (hits_1 || hits_2 || cap_clash);

    assign iss_ready_1 = ok_1 && !(conflict && prio_reg);
    assign iss_ready_2 = ok_2 && !(conflict && !prio_reg);
    assign grant_1     = iss_valid_1 && iss_ready_1;
    assign grant_2     = iss_valid_2 && iss_ready_2;
    assign prio_next   = conflict ? !prio_reg : prio_reg;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            localparam logic [REG_ADDR_W-1:0] ADDR = REG_ADDR_W'(gi);
            assign set_vec[gi] = (grant_1 && res_1 && (iss_dst_1 == ADDR))
                              || (grant_2 && res_2 && (iss_dst_2 == ADDR));
            assign clr_vec[gi] = is_reservable(ADDR)
                              && ((wb_valid_1 && (wb_addr_1 == ADDR))
                               || (wb_valid_2 && (wb_addr_2 == ADDR)));
            // A same-cycle set only happens on a free bit, so set wins here.
            assign busy_next[gi] = (busy_reg[gi] && !clr_vec[gi]) || set_vec[gi];
        end
    endgenerate

    // Any clear of a bit that is not currently busy is an illegal writeback.
    assign err_next = err_reg || (|(clr_vec & ~busy_reg));

    // Effective clears hit busy bits only; a duplicate address clears once.
    assign clr_1 = wb_valid_1 && busy_reg[wb_addr_1];
    assign clr_2 = wb_valid_2 && busy_reg[wb_addr_2]
                && !(wb_valid_1 && (wb_addr_1 == wb_addr_2));
    assign set_n = {1'b0, grant_1 && res_1} + {1'b0, grant_2 && res_2};
    assign clr_n = {1'b0, clr_1} + {1'b0, clr_2};
    assign count_next = count_reg + {6'd0, set_n} - {6'd0, clr_n};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg    <= '0;
            count_reg   <= '0;
            prio_reg    <= 1'b0;
            stall_1_reg <= '0;
            stall_2_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            busy_reg  <= busy_next;
            count_reg <= count_next;
            prio_reg  <= prio_next;
            err_reg   <= err_next;
            if (iss_valid_1 && !iss_ready_1 && (stall_1_reg != '1))
                stall_1_reg <= stall_1_reg + 1'b1;
            if (iss_valid_2 && !iss_ready_2 && (stall_2_reg != '1))
                stall_2_reg <= stall_2_reg + 1'b1;
        end
    end

    assign busy_vec    = busy_reg;
    assign busy_count  = count_reg;
    assign stall_cnt_1 = stall_1_reg;
    assign stall_cnt_2 = stall_2_reg;
    assign wb_err      = err_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a vector table for the single-cycle
// cases plus hand-written sequences for capacity, priority and async reset.
module tb_reg_scoreboard;

    logic         clk = 1'b0;
    logic         reset;
    logic         iss_valid_1, iss_ready_1, iss_dst_use_1;
    logic [20:0]  iss_src_1;
    logic [2:0]   iss_src_use_1;
    logic [6:0]   iss_dst_1;
    logic         iss_valid_2, iss_ready_2, iss_dst_use_2;
    logic [20:0]  iss_src_2;
    logic [2:0]   iss_src_use_2;
    logic [6:0]   iss_dst_2;
    logic         wb_valid_1, wb_valid_2;
    logic [6:0]   wb_addr_1, wb_addr_2;
    logic [127:0] busy_vec;
    logic [7:0]   busy_count;
    logic [15:0]  stall_cnt_1, stall_cnt_2;
    logic         wb_err;

    int total = 0;
    int bad   = 0;

    reg_scoreboard #(.MAX_BUSY(32), .STALL_W(16)) dut (
        .clk(clk), .reset(reset),
        .iss_valid_1(iss_valid_1), .iss_ready_1(iss_ready_1),
        .iss_src_1(iss_src_1), .iss_src_use_1(iss_src_use_1),
        .iss_dst_1(iss_dst_1), .iss_dst_use_1(iss_dst_use_1),
        .iss_valid_2(iss_valid_2), .iss_ready_2(iss_ready_2),
        .iss_src_2(iss_src_2), .iss_src_use_2(iss_src_use_2),
        .iss_dst_2(iss_dst_2), .iss_dst_use_2(iss_dst_use_2),
        .wb_valid_1(wb_valid_1), .wb_addr_1(wb_addr_1),
        .wb_valid_2(wb_valid_2), .wb_addr_2(wb_addr_2),
        .busy_vec(busy_vec), .busy_count(busy_count),
        .stall_cnt_1(stall_cnt_1), .stall_cnt_2(stall_cnt_2),
        .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v1;
        logic [6:0] sa1;
        logic [2:0] u1;
        logic [6:0] d1;
        logic       du1;
        logic       v2;
        logic [6:0] sa2;
        logic [2:0] u2;
        logic [6:0] d2;
        logic       du2;
        logic       w1;
        logic [6:0] a1;
        logic       w2;
        logic [6:0] a2;
        logic       r1;
        logic       r2;
        logic [7:0] cnt;
        logic       err;
        logic [6:0] idx;
        logic       bitv;
    } vec_t;

    function automatic vec_t mk(
        input logic v1, input logic [6:0] sa1, input logic [2:0] u1,
        input logic [6:0] d1, input logic du1,
        input logic v2, input logic [6:0] sa2, input logic [2:0] u2,
        input logic [6:0] d2, input logic du2,
        input logic w1, input logic [6:0] a1, input logic w2, input logic [6:0] a2,
        input logic r1, input logic r2, input logic [7:0] cnt, input logic err,
        input logic [6:0] idx, input logic bitv);
        vec_t v;
        v = '{v1, sa1, u1, d1, du1, v2, sa2, u2, d2, du2,
              w1, a1, w2, a2, r1, r2, cnt, err, idx, bitv};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        iss_valid_1 = 0; iss_src_1 = '0; iss_src_use_1 = 0; iss_dst_1 = 0; iss_dst_use_1 = 0;
        iss_valid_2 = 0; iss_src_2 = '0; iss_src_use_2 = 0; iss_dst_2 = 0; iss_dst_use_2 = 0;
        wb_valid_1 = 0; wb_addr_1 = 0; wb_valid_2 = 0; wb_addr_2 = 0;
    endtask

    task automatic drive(input vec_t v);
        iss_valid_1 = v.v1; iss_src_1 = {14'd0, v.sa1}; iss_src_use_1 = v.u1;
        iss_dst_1 = v.d1; iss_dst_use_1 = v.du1;
        iss_valid_2 = v.v2; iss_src_2 = {14'd0, v.sa2}; iss_src_use_2 = v.u2;
        iss_dst_2 = v.d2; iss_dst_use_2 = v.du2;
        wb_valid_1 = v.w1; wb_addr_1 = v.a1; wb_valid_2 = v.w2; wb_addr_2 = v.a2;
    endtask

    vec_t         vecs[12];
    logic [127:0] exp_busy;

    initial begin
        // v1 sa1 u1 d1 du1 | v2 sa2 u2 d2 du2 | w1 a1 w2 a2 | r1 r2 cnt err idx bit
        vecs[0]  = mk(1, 0, 0,  5, 1,  0, 0, 0,  0, 0,  0,  0, 0,  0,  1, 1, 1, 0,  5, 1);
        vecs[1]  = mk(0, 0, 0,  0, 0,  1, 5, 1,  0, 0,  0,  0, 0,  0,  1, 0, 1, 0,  5, 1);
        vecs[2]  = mk(0, 0, 0,  0, 0,  1, 5, 1,  0, 0,  1,  5, 0,  0,  1, 0, 0, 0,  5, 0);
        vecs[3]  = mk(0, 0, 0,  0, 0,  1, 5, 1,  0, 0,  0,  0, 0,  0,  1, 1, 0, 0,  5, 0);
        vecs[4]  = mk(1, 0, 0,  9, 1,  1, 0, 0,  9, 1,  0,  0, 0,  0,  1, 0, 1, 0,  9, 1);
        vecs[5]  = mk(1, 0, 0, 10, 1,  1, 0, 0, 10, 1,  1,  9, 0,  0,  0, 1, 1, 0, 10, 1);
        vecs[6]  = mk(1, 0, 0,  0, 1,  1, 0, 0, 20, 1,  0,  0, 0,  0,  1, 1, 1, 0, 20, 0);
        vecs[7]  = mk(0, 0, 0,  0, 0,  0, 0, 0,  0, 0,  1, 20, 1,  0,  1, 1, 1, 0,  0, 0);
        vecs[8]  = mk(0, 0, 0,  0, 0,  0, 0, 0,  0, 0,  1, 10, 1, 10,  1, 1, 0, 0, 10, 0);
        vecs[9]  = mk(1,10, 1, 11, 1,  0, 0, 0,  0, 0,  0,  0, 0,  0,  1, 1, 1, 0, 11, 1);
        vecs[10] = mk(0, 0, 0,  0, 0,  0, 0, 0,  0, 0,  1,  8, 0,  0,  1, 1, 1, 1,  8, 0);
        vecs[11] = mk(0, 0, 0,  0, 0,  0, 0, 0,  0, 0,  0,  0, 1, 11,  1, 1, 0, 1, 11, 0);

        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy_vec, '0);
        chk("rst_count", 128'(busy_count), 128'd0);
        chk("rst_err", 128'(wb_err), 128'd0);
        chk("rst_stall1", 128'(stall_cnt_1), 128'd0);
        chk("rst_stall2", 128'(stall_cnt_2), 128'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            $display("vec %0d: ready=%0b%0b (want %0b%0b)", i,
                     iss_ready_1, iss_ready_2, vecs[i].r1, vecs[i].r2);
            chk($sformatf("v%0d_ready1", i), 128'(iss_ready_1), 128'(vecs[i].r1));
            chk($sformatf("v%0d_ready2", i), 128'(iss_ready_2), 128'(vecs[i].r2));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_count", i), 128'(busy_count), 128'(vecs[i].cnt));
            chk($sformatf("v%0d_err", i), 128'(wb_err), 128'(vecs[i].err));
            chk($sformatf("v%0d_busy", i), 128'(busy_vec[vecs[i].idx]), 128'(vecs[i].bitv));
        end
        chk("stall1_after_table", 128'(stall_cnt_1), 128'd1);
        chk("stall2_after_table", 128'(stall_cnt_2), 128'd3);

        // Asynchronous reset between clock edges clears the sticky error.
        @(negedge clk);
        idle();
        reset = 1'b1;
        #1;
        $display("async reset #1: err=%0b stall1=%0d", wb_err, stall_cnt_1);
        chk("areset_err", 128'(wb_err), 128'd0);
        chk("areset_stall1", 128'(stall_cnt_1), 128'd0);
        #2 reset = 1'b0;

        // Fill 31 reservations (registers 1..32, skipping 20).
        exp_busy = '0;
        for (int r = 1; r <= 32; r++) begin
            if (r != 20) begin
                @(negedge clk);
                idle();
                iss_valid_1 = 1; iss_dst_1 = 7'(r); iss_dst_use_1 = 1;
                exp_busy[r] = 1'b1;
                @(posedge clk);
            end
        end
        @(negedge clk);
        chk("fill_count31", 128'(busy_count), 128'd31);

        // One slot left and both reserve: core 1 wins with prio reset to 0.
        idle();
        iss_valid_1 = 1; iss_dst_1 = 7'd33; iss_dst_use_1 = 1;
        iss_valid_2 = 1; iss_dst_2 = 7'd34; iss_dst_use_2 = 1;
        #1;
        $display("cap clash: ready=%0b%0b", iss_ready_1, iss_ready_2);
        chk("clash_ready1", 128'(iss_ready_1), 128'd1);
        chk("clash_ready2", 128'(iss_ready_2), 128'd0);
        exp_busy[33] = 1'b1;
        @(posedge clk);
        #1;
        chk("full_count", 128'(busy_count), 128'd32);
        chk("full_busy_vec", busy_vec, exp_busy);

        // Full: reserving issue blocked, non-writing issue still granted.
        @(negedge clk);
        idle();
        iss_valid_1 = 1; iss_dst_1 = 7'd40; iss_dst_use_1 = 1;
        iss_valid_2 = 1; iss_src_2 = {14'd0, 7'd50}; iss_src_use_2 = 3'b001;
        #1;
        $display("full: ready=%0b%0b", iss_ready_1, iss_ready_2);
        chk("full_ready1", 128'(iss_ready_1), 128'd0);
        chk("full_ready2", 128'(iss_ready_2), 128'd1);
        @(posedge clk);
        #1;
        chk("full_count_hold", 128'(busy_count), 128'd32);
        chk("full_stall1", 128'(stall_cnt_1), 128'd1);

        // Both write ports retire register 7 together: one decrement.
        @(negedge clk);
        idle();
        wb_valid_1 = 1; wb_addr_1 = 7'd7; wb_valid_2 = 1; wb_addr_2 = 7'd7;
        @(posedge clk);
        #1;
        $display("dual wb 7: count=%0d err=%0b", busy_count, wb_err);
        chk("dualwb_count", 128'(busy_count), 128'd31);
        chk("dualwb_err", 128'(wb_err), 128'd0);
        chk("dualwb_bit7", 128'(busy_vec[7]), 128'd0);

        // Writeback to now-free register 7 raises the sticky error.
        @(negedge clk);
        idle();
        wb_valid_2 = 1; wb_addr_2 = 7'd7;
        @(posedge clk);
        #1;
        chk("freewb_err", 128'(wb_err), 128'd1);
        chk("freewb_count", 128'(busy_count), 128'd31);

        // prio flipped to 1 by the capacity clash: this conflict goes to core 2.
        @(negedge clk);
        idle();
        iss_valid_1 = 1; iss_dst_1 = 7'd50; iss_dst_use_1 = 1;
        iss_valid_2 = 1; iss_dst_2 = 7'd50; iss_dst_use_2 = 1;
        #1;
        $display("prio conflict: ready=%0b%0b", iss_ready_1, iss_ready_2);
        chk("prio_ready1", 128'(iss_ready_1), 128'd0);
        chk("prio_ready2", 128'(iss_ready_2), 128'd1);
        @(posedge clk);
        #1;
        chk("prio_count", 128'(busy_count), 128'd32);
        chk("prio_bit50", 128'(busy_vec[50]), 128'd1);
        chk("prio_err_sticky", 128'(wb_err), 128'd1);

        // Reset while core 1 is stalled at capacity.
        @(negedge clk);
        idle();
        iss_valid_1 = 1; iss_dst_1 = 7'd60; iss_dst_use_1 = 1;
        #1;
        chk("stall_ready1", 128'(iss_ready_1), 128'd0);
        reset = 1'b1;
        #1;
        $display("mid-stall reset: count=%0d err=%0b ready1=%0b", busy_count, wb_err, iss_ready_1);
        chk("mreset_busy", busy_vec, '0);
        chk("mreset_count", 128'(busy_count), 128'd0);
        chk("mreset_err", 128'(wb_err), 128'd0);
        chk("mreset_stall1", 128'(stall_cnt_1), 128'd0);
        chk("mreset_ready1", 128'(iss_ready_1), 128'd1);
        #1 reset = 1'b0;
        idle();

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Issue scoreboard for the shared 128x128-bit register file used by both cores. Tracks one busy bit per register: set when a core issues an instruction that writes that register, cleared when that register is written back through one of the two register-file write ports. Gates each core's issue with a valid/ready handshake (RAW/WAW hazards, capacity limit, inter-core same-cycle conflicts). Sits between the two core decode stages and the register file.

Parameters:
MAX_BUSY, 32, maximum simultaneously reserved registers (1..126)
STALL_W, 16, width of the saturating per-core stall counters

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
iss_valid_1  in  1  core 1 presents an instruction
iss_ready_1  out  1  core 1 issue allowed this cycle (combinational)
iss_src_1  in  21  core 1 source addresses {c[6:0],b[6:0],a[6:0]}
iss_src_use_1  in  3  per-source use mask {c,b,a}
iss_dst_1  in  7  core 1 destination address
iss_dst_use_1  in  1  core 1 instruction writes a register
iss_valid_2, iss_ready_2, iss_src_2, iss_src_use_2, iss_dst_2, iss_dst_use_2  as above, core 2
wb_valid_1  in  1  mirrors register-file write_signal_1
wb_addr_1  in  7  mirrors write_addr_1
wb_valid_2  in  1  mirrors write_signal_2
wb_addr_2  in  7  mirrors write_addr_2
busy_vec  out  128  current busy bits
busy_count  out  8  number of set busy bits
stall_cnt_1  out  STALL_W  cycles core 1 was valid and not ready
stall_cnt_2  out  STALL_W  same for core 2
wb_err  out  1  sticky: writeback to a non-busy, reservable register

Behaviour:
- Reset (asynchronous, any time, including mid-stall): busy_vec=0, busy_count=0, prio=0 (core 1 favoured), stall counters=0, wb_err=0. Outputs follow immediately.
- Registers 0 (ZERO_REG) and 20 (CONST_REG) are non-reservable: never set busy, never cause a hazard, and a writeback to them is ignored (no error).
- Solo check for core k, ok_k: every used source is not busy; if dst_use, dst not busy (WAW); if it reserves, busy_count < MAX_BUSY.
- No writeback bypass: a busy bit cleared by a wb in cycle t is seen as free from cycle t+1 (the register file writes at that edge).
- Inter-core conflict: both valid, both ok, and the reserving dst of one core equals the other core's dst or any used source, or both reserve and busy_count = MAX_BUSY-1.
- Conflict resolution: grant only core (prio?2:1); the other core's ready=0; prio flips at the edge. With no conflict, ready_k = ok_k and prio is unchanged.
- Grant = valid && ready. At the edge, set busy[dst] for each granted reserving instruction.
- Writeback: at the edge, clear busy[wb_addr_k] for each wb_valid_k. Both ports with the same address clear once and decrement the count once.
- wb to a non-busy reservable register: wb_err sets and stays set until reset; busy is unaffected.
- Same-cycle set and clear of the same register cannot be legal, because a set requires the bit to be free. If it occurs, set wins and wb_err is flagged.
- busy_count at the next edge = count + sets - distinct effective clears; it stays consistent with popcount(busy_vec).
- stall_cnt_k increments when iss_valid_k && !iss_ready_k, and saturates at all-ones.
- iss_ready_k does not depend on iss_valid_k, except through the conflict term.

Decomposition:
- Package regfile_pkg: REG_ADDR_W=7, NUM_REGS=128, DATA_W=128, ZERO_REG=0, CONST_REG=20, function is_reservable(addr).
- Sub-module scb_hazard_check: combinational per-core solo check (busy_vec, srcs, mask, dst) -> ok, reserves. Instantiated twice.

Test Plan:
- Reset, then core 1 issues dst=5 -> next cycle busy_vec[5]=1, busy_count=1. Core 2 with src a=5 sees ready=0; its stall counter increments each cycle.
- wb_valid_1=1, wb_addr_1=5 at cycle t -> core 2 ready stays 0 in cycle t and becomes 1 at t+1; busy_count=0.
- Both cores issue dst=9 in the same cycle with prio=0 -> only core 1 granted, prio=1. Next conflict grants core 2.
- Issue with dst=0 or dst=20 -> no busy bit set, busy_count unchanged. A later wb to 20 leaves wb_err=0.
- Fill to MAX_BUSY=32 reservations -> next reserving issue has ready=0, while a non-writing issue (dst_use=0) with free sources is still granted.
- Both wb ports write addr 7 (busy) -> busy_count decrements by 1. Then wb to free addr 8 -> wb_err=1 until an asynchronous reset clears it.
